// File: rtl/ioport_arbiter_pkg.sv
// Shared types for the GPIO write arbiter: op encodings, FSM states, width default.
package ioport_arbiter_pkg;
  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_SET   = 2'b01,
    OP_CLR   = 2'b10,
    OP_TGL   = 2'b11
  } op_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;
endpackage

// File: rtl/ioport_arbiter_if.sv
// Request, pad and edge-flag bundle between CPU/aux requesters, the arbiter and the GPIO pads.
interface ioport_arbiter_if import ioport_arbiter_pkg::*; #(parameter int WIDTH = WIDTH_DEF);
  logic             r0_valid, r0_ready;
  logic [1:0]       r0_op;
  logic [WIDTH-1:0] r0_data;
  logic             r1_valid, r1_ready, r1_lock;
  logic [1:0]       r1_op;
  logic [WIDTH-1:0] r1_data;
  logic             dir_we;
  logic [WIDTH-1:0] dir_wd, edge_en, edge_clr;
  logic             io_we;
  logic [WIDTH-1:0] io_wd, io_dir, io_rd;
  logic [WIDTH-1:0] pin_in, out_shadow, edge_flags;
  logic             irq, locked;

  modport slave (
    input  r0_valid, r0_op, r0_data, r1_valid, r1_op, r1_data, r1_lock,
           dir_we, dir_wd, edge_en, edge_clr, io_rd,
    output r0_ready, r1_ready, io_we, io_wd, io_dir, pin_in, out_shadow,
           edge_flags, irq, locked
  );

  modport master (
    output r0_valid, r0_op, r0_data, r1_valid, r1_op, r1_data, r1_lock,
           dir_we, dir_wd, edge_en, edge_clr, io_rd,
    input  r0_ready, r1_ready, io_we, io_wd, io_dir, pin_in, out_shadow,
           edge_flags, irq, locked
  );
endinterface

// File: rtl/ioport_arbiter_edge_sync.sv
// Pin input synchroniser with sticky rising-edge flags and a registered interrupt.
module ioport_edge_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] io_rd_i,
  input  logic [WIDTH-1:0] edge_en_i,
  input  logic [WIDTH-1:0] edge_clr_i,
  output logic [WIDTH-1:0] pin_in_o,
  output logic [WIDTH-1:0] edge_flags_o,
  output logic             irq_o
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q, flags_q, flags_d, rise;
  logic             irq_q;

  assign pin_in_o = sync_q[SYNC_STAGES-1];
  assign rise     = pin_in_o & ~prev_q;
  // A rise in the same cycle as a clear wins so no edge is ever lost.
  assign flags_d  = (flags_q & ~edge_clr_i) | rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      prev_q  <= '0;
      flags_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], io_rd_i};
      prev_q  <= pin_in_o;
      flags_q <= flags_d;
      irq_q   <= |(flags_q & edge_en_i);
    end
  end

  assign edge_flags_o = flags_q;
  assign irq_o        = irq_q;
endmodule

// File: rtl/ioport_arbiter.sv
// Two-requester GPIO output arbiter: round-robin / lock FSM, masked shadow updates, pad drive.
module ioport_arbiter import ioport_arbiter_pkg::*; #(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_MAX    = 64
) (
  input  logic           clk,
  input  logic           rst,
  ioport_arbiter_if.slave bus
);
  localparam int CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

  state_e           state_q, state_d;
  logic             rr_q, rr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shadow_q, shadow_d, io_wd_q, io_dir_q;
  logic             io_we_q, gnt0, gnt1;
  op_e              sel_op;
  logic [WIDTH-1:0] sel_data;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE) begin
      // rr_q=0 favours r0 on contention
      gnt0 = bus.r0_valid && (!bus.r1_valid || !rr_q);
      gnt1 = bus.r1_valid && (!bus.r0_valid || rr_q);
    end else begin
      gnt1 = bus.r1_valid;
    end
  end

  assign sel_op   = gnt1 ? op_e'(bus.r1_op) : op_e'(bus.r0_op);
  assign sel_data = gnt1 ? bus.r1_data : bus.r0_data;

  always_comb begin
    shadow_d = shadow_q;
    if (gnt0 || gnt1) begin
      case (sel_op)
        OP_WRITE: shadow_d = sel_data;
        OP_SET:   shadow_d = shadow_q | sel_data;
        OP_CLR:   shadow_d = shadow_q & ~sel_data;
        OP_TGL:   shadow_d = shadow_q ^ sel_data;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
      if (gnt0) rr_d = 1'b1;
      if (gnt1) rr_d = 1'b0;
      if (gnt1 && bus.r1_lock) state_d = LOCKED;
    end else if (!bus.r1_lock || cnt_q == CW'(LOCK_MAX - 1)) begin
      state_d = IDLE;
      cnt_d   = '0;
      rr_d    = 1'b0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      cnt_q    <= '0;
      shadow_q <= '0;
      io_we_q  <= 1'b0;
      io_wd_q  <= '0;
      io_dir_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      io_we_q  <= gnt0 || gnt1;
      if (gnt0 || gnt1) io_wd_q <= shadow_d;
      if (bus.dir_we)   io_dir_q <= bus.dir_wd;
    end
  end

  assign bus.r0_ready   = gnt0;
  assign bus.r1_ready   = gnt1;
  assign bus.io_we      = io_we_q;
  assign bus.io_wd      = io_wd_q;
  assign bus.io_dir     = io_dir_q;
  assign bus.out_shadow = shadow_q;
  assign bus.locked     = (state_q == LOCKED);

  ioport_edge_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_edge (
    .clk          (clk),
    .rst          (rst),
    .io_rd_i      (bus.io_rd),
    .edge_en_i    (bus.edge_en),
    .edge_clr_i   (bus.edge_clr),
    .pin_in_o     (bus.pin_in),
    .edge_flags_o (bus.edge_flags),
    .irq_o        (bus.irq)
  );
endmodule

// File: doc/ioport_arbiter.md
Name: ioport_arbiter

Overview:
- Shares the 8-bit registered-output GPIO port between two write requesters: the CPU I/O bus (requester 0) and an auxiliary bit-bang engine (requester 1).
- Keeps a shadow of the output byte so requesters can issue masked set/clear/toggle operations; drives the port's we/wd/dir.
- Synchronises pin inputs and captures sticky rising-edge flags with an interrupt.
- Sits between the CPU I/O decode and the GPIO pad block.

Parameters:
- WIDTH, 8, pin count / data width
- SYNC_STAGES, 2, input synchroniser depth (min 2)
- LOCK_MAX, 64, max consecutive cycles requester 1 may hold a lock before forced release

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- r0_valid  in  1  CPU write request
- r0_ready  out  1  CPU request accepted this cycle
- r0_op  in  2  00 write, 01 set, 10 clear, 11 toggle
- r0_data  in  WIDTH  value (write) or bit mask (set/clear/toggle)
- r1_valid  in  1  aux write request
- r1_ready  out  1  aux request accepted this cycle
- r1_op  in  2  same encoding as r0_op
- r1_data  in  WIDTH  same meaning as r0_data
- r1_lock  in  1  aux requests exclusive ownership after its next accept
- dir_we  in  1  CPU direction write strobe
- dir_wd  in  WIDTH  direction value, 1 = output
- edge_en  in  WIDTH  interrupt enable per bit
- edge_clr  in  WIDTH  write-1-to-clear pulse for edge flags
- io_we  out  1  port write enable
- io_wd  out  WIDTH  port write data
- io_dir  out  WIDTH  port output-enable per pin
- io_rd  in  WIDTH  raw pin inputs from port
- pin_in  out  WIDTH  synchronised pin inputs
- out_shadow  out  WIDTH  current shadow output value
- edge_flags  out  WIDTH  sticky rising-edge flags
- irq  out  1  OR of (edge_flags & edge_en), registered
- locked  out  1  requester 1 holds the lock

Behaviour:
- Reset, asynchronous: shadow=0, io_we=0, io_wd=0, io_dir=0 (all inputs), sync chain=0, edge_flags=0, irq=0, FSM=IDLE, rr pointer favours r0, lock counter=0.
- Accept rule: a transfer occurs when valid && ready on a rising edge. ready is combinational from valid, FSM state and rr pointer. At most one accept per cycle; ready never asserts without valid.
- FSM states:
  - IDLE: round-robin between r0 and r1. If only one is valid, it is granted. If both are valid, the requester not granted last wins and the pointer flips on each accept.
  - IDLE -> LOCKED: on an r1 accept with r1_lock=1.
  - LOCKED: r0_ready=0; r1 is granted whenever r1_valid; counter increments every cycle.
  - LOCKED -> IDLE: on r1_lock=0, or counter == LOCK_MAX-1 (forced release). On exit the counter clears and the pointer is set to favour r0.
  - locked = (state == LOCKED).
- Shadow update at accept, from the granted requester's op:
  - write: shadow = data
  - set: shadow |= data
  - clear: shadow &= ~data
  - toggle: shadow ^= data
- Port drive:
  - Registered: in the cycle after an accept, io_we=1 and io_wd=new shadow; otherwise io_we=0 and io_wd holds.
  - Pin changes one further cycle later (pad output register), so accept-to-pin latency is 2 cycles.
- Direction: io_dir <= dir_wd on dir_we, one cycle latency; independent of arbitration.
- Inputs and edges:
  - io_rd passes through SYNC_STAGES flops to pin_in; a prev register holds the last pin_in.
  - Rise detect: pin_in & ~prev.
  - edge_flags <= (edge_flags & ~edge_clr) | rise. When clear and rise hit the same bit in the same cycle, set wins.
  - irq registered one cycle after flags.
- Reset mid-operation: an in-flight io_we is dropped, the lock is released, and pins return to input.

Decomposition:
- Shared package holds:
  - op encodings OP_WRITE/OP_SET/OP_CLR/OP_TGL
  - FSM state enum IDLE/LOCKED
  - WIDTH default
- One natural sub-module: ioport_edge_sync (synchroniser + edge flags + irq), instantiated once. Arbiter, FSM and shadow logic stay in the top.

Test Plan:
- Reset, then r0 write 0xA5 -> r0_ready=1 same cycle; io_we=1 with io_wd=0xA5 next cycle; out_shadow=0xA5.
- Shadow 0xA5, r0 set 0x0A, then clear 0x81, then toggle 0xFF -> shadows 0xAF, 0x2E, 0xD1; one io_we pulse per op.
- r0 and r1 both valid for 4 cycles, rr pointer initially favouring r0 -> grants r0, r1, r0, r1; never two readys in one cycle.
- r1 accepted with r1_lock=1, then r0 valid continuously, LOCK_MAX=64 -> r0_ready=0 for 64 cycles; locked falls; r0 granted on the next cycle.
- io_rd bit3 goes 0->1 with edge_en=0x08 -> edge_flags[3]=1 after SYNC_STAGES+1 cycles; irq one cycle later. edge_clr=0x08 in the same cycle as a new rise -> flag stays 1.
- rst asserted during LOCKED with io_we pending -> outputs zero immediately (asynchronous); locked=0, io_dir=0x00.
